// File: rtl/spi_slave_ram_if.sv
// SPI slave front-end for the single-port RAM; MOSI is sampled on the system clock.
// Define SPI_PARITY_EN to add an even-parity bit to both rx and tx frames.
module spi_slave_ram_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              parity_err
);

`ifdef SPI_PARITY_EN
    localparam int unsigned RX_N = WORD_W + 2;
    localparam int unsigned TX_N = WORD_W + 1;
`else
    localparam int unsigned RX_N = WORD_W + 1;
    localparam int unsigned TX_N = WORD_W;
`endif
    localparam logic [CNT_W-1:0] RX_LOAD = CNT_W'(RX_N);
    localparam logic [CNT_W-1:0] TX_LOAD = CNT_W'(TX_N - 1);

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [RX_N-1:0]   r_rx_sh, w_rx_sh_nxt;
    logic [TX_N-1:0]   r_tx_sh, w_tx_sh_nxt;
    logic [WORD_W+1:0] r_rx_data, w_rx_data_nxt;
    logic              r_miso, w_miso_nxt;
    logic              r_rx_valid, w_rx_valid_nxt;
    logic              r_par_err, w_par_err_nxt;
    logic              r_rd_seen, w_rd_seen_nxt;

    logic [WORD_W+1:0] w_frame;
    logic              w_par_ok;
    logic [TX_N-1:0]   w_tx_load;

    // Frame is complete on the edge that samples the final bit still sitting on MOSI.
`ifdef SPI_PARITY_EN
    assign w_frame   = r_rx_sh;
    assign w_par_ok  = ~^{r_rx_sh, MOSI};
    assign w_tx_load = {tx_data, ^tx_data};
`else
    assign w_frame   = {r_rx_sh, MOSI};
    assign w_par_ok  = 1'b1;
    assign w_tx_load = tx_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rx_sh    <= '0;
            r_tx_sh    <= '0;
            r_rx_data  <= '0;
            r_miso     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_par_err  <= 1'b0;
            r_rd_seen  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rx_sh    <= w_rx_sh_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_miso     <= w_miso_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_par_err  <= w_par_err_nxt;
            r_rd_seen  <= w_rd_seen_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rx_sh_nxt    = r_rx_sh;
        w_tx_sh_nxt    = r_tx_sh;
        w_rx_data_nxt  = r_rx_data;
        w_rd_seen_nxt  = r_rd_seen;
        w_miso_nxt     = 1'b0;
        w_rx_valid_nxt = 1'b0;
        w_par_err_nxt  = 1'b0;
        // Deselect aborts any frame, even on the last-bit edge, leaving rd_seen intact.
        if (r_state != IDLE && SS_n) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!SS_n) w_state_nxt = CHK_CMD;
                end
                CHK_CMD: begin
                    w_rx_sh_nxt = {r_rx_sh[RX_N-2:0], MOSI};
                    w_cnt_nxt   = RX_LOAD;
                    if (!MOSI)          w_state_nxt = WRITE;
                    else if (r_rd_seen) w_state_nxt = READ_DATA;
                    else                w_state_nxt = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (r_cnt != CNT_W'(1)) begin
                        w_rx_sh_nxt = {r_rx_sh[RX_N-2:0], MOSI};
                        w_cnt_nxt   = r_cnt - 1'b1;
                    end else if (w_par_ok) begin
                        w_rx_data_nxt  = w_frame;
                        w_rx_valid_nxt = 1'b1;
                        if (r_state == READ_DATA) begin
                            w_state_nxt = TX_WAIT;
                        end else begin
                            w_state_nxt = DONE;
                            if (r_state == READ_ADD) w_rd_seen_nxt = 1'b1;
                        end
                    end else begin
                        w_par_err_nxt = 1'b1;
                        w_state_nxt   = DONE;
                    end
                end
                TX_WAIT: begin
                    if (tx_valid) begin
                        w_tx_sh_nxt = w_tx_load;
                        w_miso_nxt  = w_tx_load[TX_N-1];
                        w_cnt_nxt   = TX_LOAD;
                        w_state_nxt = TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (r_cnt != '0) begin
                        w_miso_nxt  = r_tx_sh[TX_N-2];
                        w_tx_sh_nxt = r_tx_sh << 1;
                        w_cnt_nxt   = r_cnt - 1'b1;
                    end else begin
                        w_rd_seen_nxt = 1'b0;
                        w_state_nxt   = DONE;
                    end
                end
                DONE: ;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign MISO       = r_miso;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_par_err;

endmodule

// File: tb/tb_spi_slave_ram_if.sv
// Self-checking bench for spi_slave_ram_if: frame-level reference model, directed cases, random frames.
module tb_spi_slave_ram_if;
    localparam int W = 8;
`ifdef SPI_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NRX = W + 2 + PB;
    localparam int NTX = W + PB;

    logic         clk = 1'b0;
    logic         rst;
    logic         SS_n;
    logic         MOSI;
    logic         MISO;
    logic [W+1:0] rx_data;
    logic         rx_valid;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         parity_err;

    spi_slave_ram_if #(.WORD_W(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_valid(tx_valid), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int rxv_pulses = 0;
    int perr_pulses = 0;
    bit cmp_en = 1'b0;

    logic         e_miso = 1'b0, e_rxv = 1'b0, e_perr = 1'b0;
    logic [W+1:0] m_rx_data = '0;
    bit           m_rd_seen = 1'b0;
    logic [NTX-1:0] tx_cap = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("miso", 32'(MISO), 32'(e_miso));
            check("rx_valid", 32'(rx_valid), 32'(e_rxv));
            check("parity_err", 32'(parity_err), 32'(e_perr));
            check("rx_data", 32'(rx_data), 32'(m_rx_data));
            if (rx_valid) rxv_pulses++;
            if (parity_err) perr_pulses++;
        end
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic set_exp(input logic m, input logic v, input logic p);
        e_miso = m; e_rxv = v; e_perr = p;
    endtask

    task automatic cyc(input logic ss, input logic mosi, input logic txv, input logic [W-1:0] txd);
        SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
        @(posedge clk);
        #1;
    endtask

    task automatic finish_idle();
        cyc(1'b1, rb(), rb(), W'($urandom)); set_exp(0, 0, 0);
        cyc(1'b1, rb(), rb(), W'($urandom)); set_exp(0, 0, 0);
    endtask

    task automatic do_reset_mid();
        #1 rst = 1'b1;
        set_exp(0, 0, 0);
        m_rx_data = '0;
        m_rd_seen = 1'b0;
        #1;
        check("rst_miso", 32'(MISO), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        SS_n = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        finish_idle();
    endtask

    // One SPI frame from SS_n fall to deselect; expectations follow the bit-count rules directly.
    task automatic do_frame(input logic [1:0] cmd, input logic [W-1:0] pl, input int abort_at,
                            input bit bad_par, input int tx_delay, input logic [W-1:0] txd,
                            input int tx_abort_at, input int rst_at);
        logic [W+1:0]   fr;
        logic [NRX-1:0] bits;
        logic [NTX-1:0] txb;
        bit ok, rd, ra;
        fr = {cmd, pl};
        ok = (PB == 0) || !bad_par;
`ifdef SPI_PARITY_EN
        bits = {fr, (^fr) ^ bad_par};
        txb  = {txd, ^txd};
`else
        bits = fr;
        txb  = txd;
`endif
        rd = cmd[1] && m_rd_seen;
        ra = cmd[1] && !m_rd_seen;
        cyc(1'b0, rb(), rb(), W'($urandom)); set_exp(0, 0, 0);
        for (int k = 1; k <= NRX; k++) begin
            if (k == abort_at) begin
                finish_idle();
                return;
            end
            cyc(1'b0, bits[NRX-k], rb(), W'($urandom)); set_exp(0, 0, 0);
            if (k == NRX) begin
                if (ok) begin
                    e_rxv = 1'b1;
                    m_rx_data = fr;
                    if (ra) m_rd_seen = 1'b1;
                end else begin
                    e_perr = 1'b1;
                end
            end
        end
        if (rd && ok) begin
            for (int d = 0; d < tx_delay; d++) begin
                cyc(1'b0, rb(), 1'b0, W'($urandom)); set_exp(0, 0, 0);
            end
            for (int j = 0; j <= NTX; j++) begin
                if (j == tx_abort_at) begin
                    finish_idle();
                    return;
                end
                if (j < NTX) begin
                    cyc(1'b0, rb(), (j == 0) ? 1'b1 : rb(), (j == 0) ? txd : W'($urandom));
                    set_exp(txb[NTX-1-j], 0, 0);
                    tx_cap = {tx_cap[NTX-2:0], MISO};
                    if (j == rst_at) begin
                        do_reset_mid();
                        return;
                    end
                end else begin
                    cyc(1'b0, rb(), 1'b1, W'($urandom)); set_exp(0, 0, 0);
                    m_rd_seen = 1'b0;
                end
            end
        end
        // Lingering in DONE with tx_valid high exposes a wrong READ_DATA/TX_WAIT entry.
        repeat (1 + $urandom % 3) begin
            cyc(1'b0, rb(), 1'b1, {1'b1, (W-1)'($urandom)}); set_exp(0, 0, 0);
        end
        finish_idle();
    endtask

    initial begin
        int p0;
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check("reset_miso", 32'(MISO), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_parity_err", 32'(parity_err), 32'h0);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        cmp_en = 1'b1;

        p0 = rxv_pulses;
        do_frame(2'b00, 8'hA5, 0, 0, 0, 8'h00, -1, -1);
        check("t1_rx_data", 32'(rx_data), 32'h0A5);
        check("t1_pulses", 32'(rxv_pulses - p0), 32'd1);

        do_frame(2'b10, 8'h3C, 0, 0, 0, 8'h00, -1, -1);
        check("t2_rx_data", 32'(rx_data), 32'h23C);

        tx_cap = '0;
        do_frame(2'b11, 8'h00, 0, 0, 2, 8'hC3, -1, -1);
        check("t3_rx_data", 32'(rx_data), 32'h300);
`ifdef SPI_PARITY_EN
        check("t3_tx_bits", 32'(tx_cap), 32'h186);
`else
        check("t3_tx_bits", 32'(tx_cap), 32'hC3);
`endif
        do_frame(2'b10, 8'h55, 0, 0, 0, 8'h00, -1, -1);
        check("t3b_rx_data", 32'(rx_data), 32'h255);

        p0 = rxv_pulses;
        do_frame(2'b00, 8'hF0, 8, 0, 0, 8'h00, -1, -1);
        check("t4_abort_rx_data", 32'(rx_data), 32'h255);
        check("t4_abort_pulses", 32'(rxv_pulses - p0), 32'd0);
        do_frame(2'b01, 8'h5A, 0, 0, 0, 8'h00, -1, -1);
        check("t4_next_rx_data", 32'(rx_data), 32'h15A);

        do_frame(2'b11, 8'h81, 0, 0, 1, 8'hC3, -1, 3);
        do_frame(2'b10, 8'h12, 0, 0, 0, 8'h00, -1, -1);
        check("t5_next_rx_data", 32'(rx_data), 32'h212);

        do_frame(2'b11, 8'h44, 0, 0, 0, 8'hFF, 4, -1);
        do_frame(2'b11, 8'h45, 0, 0, 1, 8'h96, -1, -1);
        check("tx_abort_next_rx_data", 32'(rx_data), 32'h345);

        p0 = rxv_pulses;
        do_frame(2'b00, 8'h77, NRX, 0, 0, 8'h00, -1, -1);
        check("lastbit_abort_rx_data", 32'(rx_data), 32'h345);
        check("lastbit_abort_pulses", 32'(rxv_pulses - p0), 32'd0);

`ifdef SPI_PARITY_EN
        p0 = perr_pulses;
        do_frame(2'b00, 8'hA5, 0, 1, 0, 8'h00, -1, -1);
        check("t6_bad_perr", 32'(perr_pulses - p0), 32'd1);
        check("t6_bad_rx_data", 32'(rx_data), 32'h345);
        do_frame(2'b00, 8'hA5, 0, 0, 0, 8'h00, -1, -1);
        check("t6_good_rx_data", 32'(rx_data), 32'h0A5);
`endif

        for (int n = 0; n < 60; n++) begin
            int ab, ta, ra;
            ab = ($urandom % 4 == 0) ? 1 + int'($urandom % NRX) : 0;
            ta = ($urandom % 5 == 0) ? int'($urandom % (NTX + 1)) : -1;
            ra = ($urandom % 10 == 0) ? 1 + int'($urandom % (NTX - 1)) : -1;
            do_frame(2'($urandom), W'($urandom), ab, ($urandom % 4 == 0), int'($urandom % 4),
                     W'($urandom), ta, ra);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
